// File: rtl/pulpino_kernel_pkg.sv
// Shared types and helpers for the PULPino multi-channel kernel sequencer.
package pulpino_kernel_pkg;

    localparam int unsigned LP_DW_BYTES = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } kseq_state_e;

    // Number of low address bits cleared so slices stay aligned to one AXI beat.
    function automatic int unsigned slice_align_shift(input int unsigned dw_bits);
        return $clog2(dw_bits / 8);
    endfunction

endpackage

// File: rtl/pulpino_xfer_splitter.sv
// Splits one host transfer into N beat-aligned per-channel slices, registered on load.
module pulpino_xfer_splitter
    import pulpino_kernel_pkg::*;
#(
    parameter int unsigned C_NUM_CHANNELS     = 2,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = LP_DW_BYTES * 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        load_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]               base_i,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                xfer_i,
    output logic [C_NUM_CHANNELS*C_M_AXI_ADDR_WIDTH-1:0] addr_o,
    output logic [C_NUM_CHANNELS*C_XFER_SIZE_WIDTH-1:0]  size_o
);
    localparam int unsigned AW         = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned XW         = C_XFER_SIZE_WIDTH;
    localparam int unsigned N          = C_NUM_CHANNELS;
    localparam int unsigned LP_N_SHIFT = $clog2(N);
    localparam int unsigned LP_D_SHIFT = slice_align_shift(C_M_AXI_DATA_WIDTH);

    logic [XW-1:0]   chunk;
    logic [XW-1:0]   last_size;
    logic [AW-1:0]   chunk_a;
    logic [N*AW-1:0] addr_d, addr_q;
    logic [N*XW-1:0] size_d, size_q;

    // N and the beat size are powers of two, so divide/floor/multiply reduce to shifts.
    always_comb begin
        chunk     = ((xfer_i >> LP_N_SHIFT) >> LP_D_SHIFT) << LP_D_SHIFT;
        chunk_a   = AW'(chunk);
        last_size = xfer_i - XW'(N - 1) * chunk;
        addr_d    = '0;
        size_d    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            addr_d[i*AW +: AW] = base_i + AW'(i) * chunk_a;
            size_d[i*XW +: XW] = (i == N - 1) ? last_size : chunk;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            size_q <= '0;
        end else if (load_i) begin
            addr_q <= addr_d;
            size_q <= size_d;
        end
    end

    assign addr_o = addr_q;
    assign size_o = size_q;

endmodule

// File: rtl/pulpino_kernel_sequencer.sv
// ap_ctrl_hs sequencer launching N read->PULPino->write channels and gathering their completion.
module pulpino_kernel_sequencer
    import pulpino_kernel_pkg::*;
#(
    parameter int unsigned C_NUM_CHANNELS     = 2,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = LP_DW_BYTES * 8,
    parameter int unsigned C_NUM_SCALARS      = 4,
    parameter int unsigned C_TIMEOUT_WIDTH    = 32
) (
    input  logic                                         aclk,
    input  logic                                         aresetn,
    input  logic                                         ap_start,
    output logic                                         ap_idle,
    output logic                                         ap_ready,
    output logic                                         ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]                ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                 ctrl_xfer_size_in_bytes,
    input  logic [C_NUM_CHANNELS-1:0]                    ctrl_ch_enable,
    input  logic [C_TIMEOUT_WIDTH-1:0]                   ctrl_timeout_cycles,
    input  logic [32*C_NUM_SCALARS-1:0]                  scalar_i,
    output logic [32*C_NUM_SCALARS-1:0]                  scalar_o,
    output logic [C_NUM_CHANNELS-1:0]                    ch_start,
    output logic [C_NUM_CHANNELS*C_M_AXI_ADDR_WIDTH-1:0] ch_addr_offset,
    output logic [C_NUM_CHANNELS*C_XFER_SIZE_WIDTH-1:0]  ch_xfer_size,
    input  logic [C_NUM_CHANNELS-1:0]                    ch_read_done,
    input  logic [C_NUM_CHANNELS-1:0]                    ch_write_done,
    output logic                                         status_timeout,
    output logic [C_NUM_CHANNELS-1:0]                    status_done_mask,
    output logic [C_NUM_CHANNELS-1:0]                    status_rd_mask,
    output logic [C_TIMEOUT_WIDTH-1:0]                   status_cycles
);
    localparam int unsigned N  = C_NUM_CHANNELS;
    localparam int unsigned TW = C_TIMEOUT_WIDTH;

    kseq_state_e               state_q, state_d;
    logic [32*C_NUM_SCALARS-1:0] scalar_q;
    logic [N-1:0]              en_q, done_q, rd_q, ch_start_q;
    logic [N-1:0]              done_nx, rd_nx;
    logic [TW-1:0]             tmo_q, cnt_q, cnt_inc, cycles_q;
    logic                      timeout_q;
    logic                      all_done, tmo_hit, run_exit;

    always_comb begin
        state_d  = state_q;
        done_nx  = done_q | (ch_write_done & en_q);
        rd_nx    = rd_q | (ch_read_done & en_q);
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + TW'(1);
        all_done = &(done_nx | ~en_q);
        tmo_hit  = (tmo_q != '0) && (cnt_q == tmo_q - TW'(1));
        run_exit = all_done | tmo_hit;
        case (state_q)
            ST_IDLE:   if (ap_start) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN:    if (run_exit) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Status is captured on the RUN exit edge so it is already valid while ap_done pulses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            scalar_q   <= '0;
            en_q       <= '0;
            tmo_q      <= '0;
            done_q     <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            cycles_q   <= '0;
            timeout_q  <= 1'b0;
            ch_start_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_start_q <= '0;
            case (state_q)
                ST_LAUNCH: begin
                    scalar_q   <= scalar_i;
                    en_q       <= ctrl_ch_enable;
                    tmo_q      <= ctrl_timeout_cycles;
                    done_q     <= '0;
                    rd_q       <= '0;
                    cnt_q      <= '0;
                    timeout_q  <= 1'b0;
                    ch_start_q <= ctrl_ch_enable;
                end
                ST_RUN: begin
                    done_q <= done_nx;
                    rd_q   <= rd_nx;
                    cnt_q  <= cnt_inc;
                    if (run_exit) begin
                        cycles_q  <= cnt_inc;
                        timeout_q <= ~all_done;
                    end
                end
                default: ;
            endcase
        end
    end

    pulpino_xfer_splitter #(
        .C_NUM_CHANNELS    (C_NUM_CHANNELS),
        .C_M_AXI_ADDR_WIDTH(C_M_AXI_ADDR_WIDTH),
        .C_XFER_SIZE_WIDTH (C_XFER_SIZE_WIDTH),
        .C_M_AXI_DATA_WIDTH(C_M_AXI_DATA_WIDTH)
    ) u_splitter (
        .clk_i (aclk),
        .rst_ni(aresetn),
        .load_i(state_q == ST_LAUNCH),
        .base_i(ctrl_addr_offset),
        .xfer_i(ctrl_xfer_size_in_bytes),
        .addr_o(ch_addr_offset),
        .size_o(ch_xfer_size)
    );

    assign ap_idle          = (state_q == ST_IDLE);
    assign ap_ready         = (state_q == ST_LAUNCH);
    assign ap_done          = (state_q == ST_DONE);
    assign scalar_o         = scalar_q;
    assign ch_start         = ch_start_q;
    assign status_timeout   = timeout_q;
    assign status_done_mask = done_q;
    assign status_rd_mask   = rd_q;
    assign status_cycles    = cycles_q;

endmodule

// File: tb/tb_pulpino_kernel_sequencer.sv
// Randomized self-checking bench for pulpino_kernel_sequencer with a per-run behavioural model.
module tb_pulpino_kernel_sequencer;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned XW = 32;
    localparam int unsigned DW = 512;
    localparam int unsigned NS = 4;
    localparam int unsigned TW = 32;
    localparam int unsigned DB = DW / 8;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              ap_start = 1'b0;
    logic              ap_idle, ap_ready, ap_done;
    logic [AW-1:0]     ctrl_addr_offset = '0;
    logic [XW-1:0]     ctrl_xfer_size_in_bytes = '0;
    logic [N-1:0]      ctrl_ch_enable = '0;
    logic [TW-1:0]     ctrl_timeout_cycles = '0;
    logic [32*NS-1:0]  scalar_i = '0;
    logic [32*NS-1:0]  scalar_o;
    logic [N-1:0]      ch_start;
    logic [N*AW-1:0]   ch_addr_offset;
    logic [N*XW-1:0]   ch_xfer_size;
    logic [N-1:0]      ch_read_done = '0;
    logic [N-1:0]      ch_write_done = '0;
    logic              status_timeout;
    logic [N-1:0]      status_done_mask, status_rd_mask;
    logic [TW-1:0]     status_cycles;

    pulpino_kernel_sequencer #(
        .C_NUM_CHANNELS    (N),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_XFER_SIZE_WIDTH (XW),
        .C_M_AXI_DATA_WIDTH(DW),
        .C_NUM_SCALARS     (NS),
        .C_TIMEOUT_WIDTH   (TW)
    ) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .ap_start               (ap_start),
        .ap_idle                (ap_idle),
        .ap_ready               (ap_ready),
        .ap_done                (ap_done),
        .ctrl_addr_offset       (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
        .ctrl_ch_enable         (ctrl_ch_enable),
        .ctrl_timeout_cycles    (ctrl_timeout_cycles),
        .scalar_i               (scalar_i),
        .scalar_o               (scalar_o),
        .ch_start               (ch_start),
        .ch_addr_offset         (ch_addr_offset),
        .ch_xfer_size           (ch_xfer_size),
        .ch_read_done           (ch_read_done),
        .ch_write_done          (ch_write_done),
        .status_timeout         (status_timeout),
        .status_done_mask       (status_done_mask),
        .status_rd_mask         (status_rd_mask),
        .status_cycles          (status_cycles)
    );

    always #5 aclk = ~aclk;

    longint unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Per-run pulse schedule: RUN cycle (1-based) of each channel's pulse, 0 = never.
    int unsigned wd_at [N];
    int unsigned rd_at [N];

    bit              prev_hold = 1'b0;
    int unsigned     prev_e = 0;
    longint unsigned prev_rdy = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_slices(input logic [AW-1:0] base, input logic [XW-1:0] xfer,
                                output logic [N*AW-1:0] ea, output logic [N*XW-1:0] es);
        longint unsigned b;
        int unsigned     x, chunk;
        b = base;
        x = xfer;
        chunk = ((x / N) / DB) * DB;
        for (int i = 0; i < N; i++) begin
            ea[i*AW +: AW] = b + longint'(i) * longint'(chunk);
            es[i*XW +: XW] = (i == N - 1) ? x - (N - 1) * chunk : chunk;
        end
    endtask

    task automatic model_run(input logic [N-1:0] mask, input int unsigned tmo,
                             output int unsigned e, output bit tf,
                             output logic [N-1:0] dm, output logic [N-1:0] rm);
        int unsigned c;
        bit          incomplete;
        c = 1;
        incomplete = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (wd_at[i] == 0) incomplete = 1'b1;
                else if (wd_at[i] > c) c = wd_at[i];
            end
        end
        if (incomplete || (tmo != 0 && tmo < c)) begin
            e = tmo;
            tf = 1'b1;
        end else begin
            e = c;
            tf = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            dm[i] = mask[i] && wd_at[i] != 0 && wd_at[i] <= e;
            rm[i] = mask[i] && rd_at[i] != 0 && rd_at[i] <= e;
        end
    endtask

    task automatic wait_ready();
        bit got;
        got = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge aclk);
            if (ap_ready) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("ap_ready_seen", 256'(got), 256'(1'b1));
    endtask

    task automatic do_run(input logic [AW-1:0] base, input logic [XW-1:0] xfer,
                          input logic [N-1:0] mask, input int unsigned tmo,
                          input logic [32*NS-1:0] sc, input bit hold);
        logic [N*AW-1:0] ea;
        logic [N*XW-1:0] es;
        int unsigned     e, seen;
        bit              tf;
        logic [N-1:0]    dm, rm;

        ctrl_addr_offset        = base;
        ctrl_xfer_size_in_bytes = xfer;
        ctrl_ch_enable          = mask;
        ctrl_timeout_cycles     = TW'(tmo);
        scalar_i                = sc;
        ap_start                = 1'b1;
        wait_ready();
        if (prev_hold) check_eq("ready_spacing", 256'(cyc - prev_rdy), 256'(prev_e + 3));
        prev_rdy = cyc;
        if (!hold) ap_start = 1'b0;

        model_slices(base, xfer, ea, es);
        model_run(mask, tmo, e, tf, dm, rm);

        seen = 0;
        for (int unsigned k = 1; k <= e + 4; k++) begin
            @(negedge aclk);
            if (k == 1) begin
                check_eq("ch_start", 256'(ch_start), 256'(mask));
                check_eq("ch_addr", 256'(ch_addr_offset), 256'(ea));
                check_eq("ch_size", 256'(ch_xfer_size), 256'(es));
                check_eq("scalar_o", 256'(scalar_o), 256'(sc));
            end else if (k == 2) begin
                check_eq("ch_start_once", 256'(ch_start), 256'(0));
            end
            if (ap_done) begin
                seen = k;
                ch_write_done = '0;
                ch_read_done  = '0;
                break;
            end
            // Control inputs wander during RUN; none of it may leak into the run.
            ctrl_addr_offset        = {$urandom, $urandom};
            ctrl_xfer_size_in_bytes = $urandom;
            ctrl_ch_enable          = N'($urandom);
            ctrl_timeout_cycles     = $urandom;
            scalar_i                = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < N; i++) begin
                ch_write_done[i] = (wd_at[i] == k);
                ch_read_done[i]  = (rd_at[i] == k);
            end
        end
        check_eq("done_latency", 256'(seen), 256'(e + 1));
        check_eq("scalar_hold", 256'(scalar_o), 256'(sc));
        check_eq("addr_hold", 256'(ch_addr_offset), 256'(ea));
        check_eq("status_timeout", 256'(status_timeout), 256'(tf));
        check_eq("status_done_mask", 256'(status_done_mask), 256'(dm));
        check_eq("status_rd_mask", 256'(status_rd_mask), 256'(rm));
        check_eq("status_cycles", 256'(status_cycles), 256'(e));
        @(negedge aclk);
        check_eq("idle_after_done", 256'(ap_idle), 256'(1'b1));
        prev_hold = hold;
        prev_e    = e;
    endtask

    task automatic set_sched(input int unsigned w0, input int unsigned w1,
                             input int unsigned w2, input int unsigned w3);
        wd_at[0] = w0; wd_at[1] = w1; wd_at[2] = w2; wd_at[3] = w3;
        for (int i = 0; i < N; i++) rd_at[i] = (wd_at[i] > 1) ? wd_at[i] - 1 : 0;
    endtask

    initial begin
        logic [N-1:0] m;
        int unsigned  t;

        repeat (3) @(negedge aclk);
        check_eq("rst_idle", 256'(ap_idle), 256'(1'b1));
        check_eq("rst_ready", 256'(ap_ready), 256'(0));
        check_eq("rst_done", 256'(ap_done), 256'(0));
        check_eq("rst_addr", 256'(ch_addr_offset), 256'(0));
        check_eq("rst_status", 256'({status_timeout, status_cycles}), 256'(0));
        aresetn = 1'b1;
        @(negedge aclk);

        set_sched(10, 20, 10, 20);
        do_run(64'h1000, 32'h1000, 4'b1111, 0, 128'h1111_2222_3333_4444, 1'b0);
        set_sched(7, 7, 7, 7);
        do_run(64'h2000, 32'h1040, 4'b1111, 0, 128'h5, 1'b0);
        set_sched(0, 0, 0, 0);
        do_run(64'h0, 32'h800, 4'b0001, 100, 128'h6, 1'b0);
        set_sched(3, 3, 3, 3);
        do_run(64'h40, 32'h400, 4'b0000, 0, 128'h7, 1'b0);
        set_sched(0, 5, 9, 0);
        do_run(64'hFFFF_FFFF_FFFF_FF00, 32'd200, 4'b0110, 0, 128'h8, 1'b0);
        set_sched(5, 8, 0, 0);
        do_run(64'hFFFF_FFFF_FFFF_F000, 32'h2000, 4'b0011, 8, 128'h9, 1'b0);
        set_sched(0, 0, 0, 0);
        do_run(64'h100, 32'h1000, 4'b0000, 0, 128'hAAAA, 1'b1);
        set_sched(4, 6, 0, 0);
        do_run(64'h200, 32'h1000, 4'b0011, 0, 128'hBBBB, 1'b0);

        // Asynchronous reset in the middle of a run.
        set_sched(0, 0, 0, 0);
        ctrl_ch_enable = 4'b1111;
        ctrl_timeout_cycles = '0;
        scalar_i = 128'hDEAD;
        ap_start = 1'b1;
        wait_ready();
        ap_start = 1'b0;
        repeat (5) @(negedge aclk);
        check_eq("midrun_busy", 256'(ap_idle), 256'(0));
        aresetn = 1'b0;
        #1;
        check_eq("arst_idle", 256'(ap_idle), 256'(1'b1));
        check_eq("arst_scalar", 256'(scalar_o), 256'(0));
        check_eq("arst_size", 256'(ch_xfer_size), 256'(0));
        check_eq("arst_status", 256'({status_cycles, status_done_mask, status_rd_mask}), 256'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        ch_write_done = '1;
        ch_read_done  = '1;
        @(negedge aclk);
        ch_write_done = '0;
        ch_read_done  = '0;
        check_eq("stale_done_ignored", 256'({ap_idle, ap_done, status_done_mask}), 256'({1'b1, 1'b0, 4'b0}));
        prev_hold = 1'b0;

        for (int r = 0; r < 25; r++) begin
            m = N'($urandom);
            t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            for (int i = 0; i < N; i++) begin
                wd_at[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 30);
                if (t == 0 && m[i] && wd_at[i] == 0) wd_at[i] = $urandom_range(1, 30);
                rd_at[i] = $urandom_range(0, 30);
            end
            do_run({$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 300)) : XW'($urandom_range(0, 32'h20000)),
                   m, t, {$urandom, $urandom, $urandom, $urandom}, r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulpino_kernel_sequencer.md
Name: pulpino_kernel_sequencer

Overview:
- Parametrised successor to the single-pipeline kernel control in the PULPino Vitis L3 wrapper.
- Drives N parallel read→PULPino→write channels from one ap_ctrl_hs handshake.
- Latches scalar arguments once per launch and splits the host transfer into per-channel address/size slices.
- Launches only enabled channels, waits for all their write-done pulses (or a timeout), then raises ap_done with status.

Parameters:
C_NUM_CHANNELS, 2, number of channel pipelines (power of 2, 1..8)
C_M_AXI_ADDR_WIDTH, 64, address width
C_XFER_SIZE_WIDTH, 32, byte-count width
C_M_AXI_DATA_WIDTH, 512, AXI data width; slice sizes align to C_M_AXI_DATA_WIDTH/8 bytes
C_NUM_SCALARS, 4, number of 32-bit scalar arguments latched per launch
C_TIMEOUT_WIDTH, 32, timeout/cycle counter width

Ports:
aclk  in  1  kernel clock
aresetn  in  1  asynchronous active-low reset
ap_start  in  1  host start, level
ap_idle  out  1  high in IDLE
ap_ready  out  1  one-cycle pulse on the launch cycle
ap_done  out  1  one-cycle pulse on completion
ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  base byte address
ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  total bytes
ctrl_ch_enable  in  C_NUM_CHANNELS  channel enable mask
ctrl_timeout_cycles  in  C_TIMEOUT_WIDTH  timeout; 0 = disabled
scalar_i  in  32*C_NUM_SCALARS  scalar args (spi_enable, use_qspi, spi_addr_idx, instr_num, ...)
scalar_o  out  32*C_NUM_SCALARS  latched scalars
ch_start  out  C_NUM_CHANNELS  per-channel one-cycle start pulse
ch_addr_offset  out  C_NUM_CHANNELS*C_M_AXI_ADDR_WIDTH  per-channel base address
ch_xfer_size  out  C_NUM_CHANNELS*C_XFER_SIZE_WIDTH  per-channel byte count
ch_read_done  in  C_NUM_CHANNELS  per-channel read-done pulse
ch_write_done  in  C_NUM_CHANNELS  per-channel write-done pulse; this is channel completion
status_timeout  out  1  last run ended by timeout
status_done_mask  out  C_NUM_CHANNELS  write-done bits captured in last run
status_rd_mask  out  C_NUM_CHANNELS  read-done bits captured in last run
status_cycles  out  C_TIMEOUT_WIDTH  cycles spent in RUN for last run

Behaviour:
- Reset: all state flops clear asynchronously on aresetn=0, from any state, including mid-run. Outputs after reset:
  - state IDLE, ap_idle=1.
  - ap_ready, ap_done, ch_start all 0.
  - scalar_o, ch_addr_offset, ch_xfer_size, all status outputs 0.
  - Channels in flight are not tracked after reset.
- FSM states: IDLE, LAUNCH, RUN, DONE.
- IDLE → LAUNCH when ap_start=1.
- LAUNCH (1 cycle):
  - Register scalar_i→scalar_o, the enable mask, and the timeout value.
  - Register slices. With D = data-width bytes:
    - chunk = floor((xfer/N)/D)*D.
    - Channel i: addr = base + i*chunk, size = chunk.
    - Last channel: size = xfer − (N−1)*chunk, carrying the remainder.
  - Clear the done/rd masks and the cycle counter.
  - Pulse ap_ready.
  - ch_start pulses in the cycle after LAUNCH (first RUN cycle), so addr/size are stable one cycle before start. Only enabled bits pulse.
- RUN:
  - Counter increments each cycle, saturating at all-ones.
  - ch_write_done/ch_read_done pulses for enabled channels OR into sticky masks. Simultaneous pulses are all captured; pulses for disabled channels are ignored.
  - Pulses outside RUN are ignored.
  - Exit to DONE when (done_mask|~enable)==all-ones, or when timeout≠0 and counter==timeout−1 (status_timeout=1).
  - If completion and timeout happen in the same cycle, completion wins (status_timeout=0).
  - Enable mask all-zero: first RUN cycle satisfies completion; no ch_start is issued; status_cycles=1.
- DONE (1 cycle): pulse ap_done, latch status_cycles, → IDLE.
  - ap_start still high in DONE does not relaunch until IDLE has been seen for one cycle. Minimum launch-to-launch spacing is 4 cycles.
- xfer < N*D: chunk=0, and the last channel takes all bytes.
- Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH.
- Control inputs are sampled only in LAUNCH; changes during RUN have no effect.

Decomposition:
- Package pulpino_kernel_pkg:
  - state enum (IDLE/LAUNCH/RUN/DONE).
  - localparam function clog2-based slice-alignment helper.
  - LP_DW_BYTES constant.
- Sub-module pulpino_xfer_splitter: combinational/registered slice computation for N channels, instantiated once.

Test Plan:
- N=2, base=0x1000, xfer=0x1000, mask=2'b11 → ch_addr={0x1000,0x1800}, sizes 0x800 each; ch_start=2'b11 one cycle after ap_ready. ch_write_done[0] at t+10, [1] at t+20 → ap_done one cycle after t+20; status_done_mask=2'b11, status_timeout=0.
- N=4, xfer=0x1040, D=64 → chunk=0x400, ch3 size=0x440; both ch_write_done pulses land in the same cycle → both captured, single ap_done.
- mask=2'b01, timeout=100, no done pulses → ap_done after RUN cycle 100; status_timeout=1, status_done_mask=0, status_cycles=100.
- mask=0 → no ch_start, ap_done 2 cycles after ap_ready; status_cycles=1.
- Assert aresetn=0 mid-RUN → all outputs 0, ap_idle=1 immediately (asynchronous). A stale ch_write_done after release is ignored. New ap_start launches normally.
- ap_start held high across two runs; scalar_i changed during RUN → second launch latches the new scalars; ap_ready pulses are exactly 4 cycles apart minimum; scalar_o unchanged during the first RUN.
